// File: rtl/mure_pkg.sv
// rtl/mure_pkg.sv - shared retirement/trace types and the branch map constants
package mure_pkg;

  localparam int ITYPE_LEN    = 4;
  localparam int BMAP_LEN     = 31;
  localparam int BMAP_CNT_LEN = 5;

  localparam logic [ITYPE_LEN-1:0] ITYPE_NT_BRANCH = ITYPE_LEN'(4);
  localparam logic [ITYPE_LEN-1:0] ITYPE_T_BRANCH  = ITYPE_LEN'(5);

  typedef struct packed {
    logic [BMAP_CNT_LEN-1:0] count;
    logic [BMAP_LEN-1:0]     map;
    logic                    full;
  } bmap_snap_s;

  function automatic logic is_branch(input logic [ITYPE_LEN-1:0] itype);
    return (itype == ITYPE_NT_BRANCH) || (itype == ITYPE_T_BRANCH);
  endfunction

endpackage

// File: rtl/te_branch_map.sv
// rtl/te_branch_map.sv - accumulates conditional-branch outcomes into an E-Trace
// branch map and emits a registered snapshot on full or flush
module te_branch_map
  import mure_pkg::*;
#(
  parameter int N       = 1,
  parameter int MAP_LEN = 31,
  localparam int CNT_W  = $clog2(MAP_LEN + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [N-1:0]           valid_i,
  input  logic [N*ITYPE_LEN-1:0] itype_i,
  input  logic                   flush_i,
  output logic [CNT_W-1:0]       branches_o,
  output logic [MAP_LEN-1:0]     branch_map_o,
  output logic                   snap_valid_o,
  output logic [CNT_W-1:0]       snap_branches_o,
  output logic [MAP_LEN-1:0]     snap_map_o,
  output logic                   snap_full_o
);

  logic [CNT_W-1:0]   count_q, count_d;
  logic [MAP_LEN-1:0] map_q, map_d;
  logic               pend_q, pend_d;
  logic               snap_valid_q, snap_valid_d;
  logic [CNT_W-1:0]   snap_cnt_q, snap_cnt_d;
  logic [MAP_LEN-1:0] snap_map_q, snap_map_d;
  logic               snap_full_q, snap_full_d;

  logic [CNT_W-1:0]   walk_cnt;
  logic [MAP_LEN-1:0] walk_map;
  logic [MAP_LEN-1:0] full_map;
  logic               full_hit;
  logic [ITYPE_LEN-1:0] lane_itype;

  always_comb begin
    // A pending flush hands the old map to the snapshot, so this cycle starts fresh.
    walk_cnt   = pend_q ? '0 : count_q;
    walk_map   = pend_q ? '0 : map_q;
    full_hit   = 1'b0;
    full_map   = '0;
    lane_itype = '0;
    for (int i = 0; i < N; i++) begin
      lane_itype = itype_i[i*ITYPE_LEN +: ITYPE_LEN];
      if (valid_i[i] && is_branch(lane_itype)) begin
        walk_map[walk_cnt] = (lane_itype == ITYPE_NT_BRANCH);
        walk_cnt           = walk_cnt + CNT_W'(1);
        if (walk_cnt == CNT_W'(MAP_LEN)) begin
          full_hit = 1'b1;
          full_map = walk_map;
          walk_map = '0;
          walk_cnt = '0;
        end
      end
    end

    count_d      = walk_cnt;
    map_d        = walk_map;
    pend_d       = pend_q;
    snap_valid_d = 1'b0;
    snap_cnt_d   = '0;
    snap_map_d   = '0;
    snap_full_d  = 1'b0;

    if (full_hit) begin
      snap_valid_d = 1'b1;
      snap_cnt_d   = CNT_W'(MAP_LEN);
      snap_map_d   = full_map;
      snap_full_d  = 1'b1;
      pend_d       = pend_q | flush_i;
    end else if (pend_q) begin
      snap_valid_d = 1'b1;
      snap_cnt_d   = count_q;
      snap_map_d   = map_q;
      pend_d       = 1'b0;
    end else if (flush_i) begin
      snap_valid_d = 1'b1;
      snap_cnt_d   = walk_cnt;
      snap_map_d   = walk_map;
      count_d      = '0;
      map_d        = '0;
    end

    if (!enable_i) begin
      count_d      = '0;
      map_d        = '0;
      pend_d       = 1'b0;
      snap_valid_d = 1'b0;
      snap_cnt_d   = '0;
      snap_map_d   = '0;
      snap_full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q      <= '0;
      map_q        <= '0;
      pend_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_cnt_q   <= '0;
      snap_map_q   <= '0;
      snap_full_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      map_q        <= map_d;
      pend_q       <= pend_d;
      snap_valid_q <= snap_valid_d;
      snap_cnt_q   <= snap_cnt_d;
      snap_map_q   <= snap_map_d;
      snap_full_q  <= snap_full_d;
    end
  end

  assign branches_o      = count_q;
  assign branch_map_o    = map_q;
  assign snap_valid_o    = snap_valid_q;
  assign snap_branches_o = snap_cnt_q;
  assign snap_map_o      = snap_map_q;
  assign snap_full_o     = snap_full_q;

endmodule

// File: tb/tb_te_branch_map.sv
// tb/tb_te_branch_map.sv - directed and random checks of te_branch_map against a
// queue-based branch map model
module tb_te_branch_map;
  import mure_pkg::*;

  localparam int N       = 2;
  localparam int MAP_LEN = 31;
  localparam int CNT_W   = $clog2(MAP_LEN + 1);

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   enable_i;
  logic [N-1:0]           valid_i;
  logic [N*ITYPE_LEN-1:0] itype_i;
  logic                   flush_i;
  logic [CNT_W-1:0]       branches_o;
  logic [MAP_LEN-1:0]     branch_map_o;
  logic                   snap_valid_o;
  logic [CNT_W-1:0]       snap_branches_o;
  logic [MAP_LEN-1:0]     snap_map_o;
  logic                   snap_full_o;

  te_branch_map #(.N(N), .MAP_LEN(MAP_LEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .valid_i(valid_i),
    .itype_i(itype_i), .flush_i(flush_i), .branches_o(branches_o),
    .branch_map_o(branch_map_o), .snap_valid_o(snap_valid_o),
    .snap_branches_o(snap_branches_o), .snap_map_o(snap_map_o),
    .snap_full_o(snap_full_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Model state: the live map is a queue of outcome bits, oldest first.
  bit   mq[$];
  bit   mpend;
  int   e_cnt, e_sc;
  logic [63:0] e_map, e_sm;
  logic e_sv, e_sf;

  function automatic logic [63:0] pack(input bit q[$]);
    logic [63:0] m = '0;
    for (int k = 0; k < q.size(); k++) m[k] = q[k];
    return m;
  endfunction

  task automatic model_clear();
    mq.delete();
    mpend = 1'b0;
    e_cnt = 0; e_map = '0; e_sv = 1'b0; e_sc = 0; e_sm = '0; e_sf = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [N-1:0] v,
                            input logic [N*ITYPE_LEN-1:0] it, input logic fl);
    bit pre[$];
    bit fq[$];
    bit full;
    bit had_pend;
    int t;
    e_sv = 1'b0; e_sc = 0; e_sm = '0; e_sf = 1'b0;
    if (!en) begin
      model_clear();
      return;
    end
    pre = mq;
    had_pend = mpend;
    full = 1'b0;
    if (had_pend) mq.delete();
    for (int i = 0; i < N; i++) begin
      t = int'(it[i*ITYPE_LEN +: ITYPE_LEN]);
      if (v[i] && (t == 4 || t == 5)) begin
        mq.push_back(t == 4);
        if (mq.size() == MAP_LEN) begin
          full = 1'b1;
          fq = mq;
          mq.delete();
        end
      end
    end
    if (full) begin
      e_sv = 1'b1; e_sc = MAP_LEN; e_sm = pack(fq); e_sf = 1'b1;
      mpend = had_pend | fl;
    end else if (had_pend) begin
      e_sv = 1'b1; e_sc = pre.size(); e_sm = pack(pre);
      mpend = 1'b0;
    end else if (fl) begin
      e_sv = 1'b1; e_sc = mq.size(); e_sm = pack(mq);
      mq.delete();
    end
    e_cnt = mq.size();
    e_map = pack(mq);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".branches"}, 64'(branches_o), 64'(e_cnt));
    chk({tag, ".map"}, 64'(branch_map_o), e_map);
    chk({tag, ".snap_valid"}, 64'(snap_valid_o), 64'(e_sv));
    chk({tag, ".snap_count"}, 64'(snap_branches_o), 64'(e_sc));
    chk({tag, ".snap_map"}, 64'(snap_map_o), e_sm);
    chk({tag, ".snap_full"}, 64'(snap_full_o), 64'(e_sf));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
  task automatic step(input string tag, input logic en, input logic [N-1:0] v,
                      input logic [ITYPE_LEN-1:0] t0, input logic [ITYPE_LEN-1:0] t1,
                      input logic fl);
    enable_i = en; valid_i = v; itype_i = {t1, t0}; flush_i = fl;
    model_step(en, v, {t1, t0}, fl);
    @(posedge clk_i);
    #1;
    chk_all(tag);
  endtask

  initial begin
    int t0, t1;
    rst_ni = 1'b0; enable_i = 1'b0; valid_i = '0; itype_i = '0; flush_i = 1'b0;
    model_clear();
    #12;
    chk_all("reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Two branches in one cycle, then idle
    step("two", 1, 2'b11, 4, 5, 0);
    chk("two.count_const", 64'(branches_o), 64'd2);
    chk("two.map_const", 64'(branch_map_o), 64'b01);
    step("idle", 1, 2'b00, 0, 0, 0);

    // Fill exactly on lane 0, residual on lane 1
    step("clr1", 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < 30; k++) step("fill_nt", 1, 2'b01, 4, 0, 0);
    step("full", 1, 2'b11, 4, 5, 0);
    chk("full.snap_map_const", 64'(snap_map_o), 64'h7FFF_FFFF);
    chk("full.snap_full_const", 64'(snap_full_o), 64'd1);
    chk("full.live_count_const", 64'(branches_o), 64'd1);

    // Plain flush with a branch in the same cycle
    step("clr2", 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < 5; k++) step("acc5", 1, 2'b01, 4, 0, 0);
    step("flush", 1, 2'b01, 5, 0, 1);
    chk("flush.count_const", 64'(snap_branches_o), 64'd6);
    chk("flush.map_const", 64'(snap_map_o), 64'h1F);

    // Flush coinciding with full: flush deferred one cycle
    step("clr3", 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < 30; k++) step("acc30", 1, 2'b01, 4, 0, 0);
    step("full_flush", 1, 2'b11, 5, 4, 1);
    chk("full_flush.count_const", 64'(snap_branches_o), 64'd31);
    step("pend_snap", 1, 2'b01, 4, 0, 0);
    chk("pend_snap.count_const", 64'(snap_branches_o), 64'd1);
    chk("pend_snap.full_const", 64'(snap_full_o), 64'd0);
    chk("pend_snap.live_const", 64'(branches_o), 64'd1);
    step("pend_done", 1, 2'b00, 0, 0, 0);

    // Non-branch traffic and invalid lanes
    step("ign1", 1, 2'b00, 4, 4, 0);
    step("ign2", 1, 2'b11, 1, 2, 0);
    step("ign3", 1, 2'b11, 6, 0, 0);
    step("zero_flush_prep", 0, 2'b00, 0, 0, 0);
    step("zero_flush", 1, 2'b00, 0, 0, 1);

    // Enable drop clears state
    for (int k = 0; k < 5; k++) step("acc10", 1, 2'b11, 5, 4, 0);
    step("disable", 0, 2'b11, 4, 4, 1);
    chk("disable.count_const", 64'(branches_o), 64'd0);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 4; k++) step("acc_rst", 1, 2'b11, 4, 5, 0);
    step("pre_rst", 1, 2'b01, 4, 0, 1);
    rst_ni = 1'b0;
    model_clear();
    #2;
    chk_all("async_rst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    for (int k = 0; k < 800; k++) begin
      t0 = ($urandom_range(0, 3) != 0) ? 4 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 7));
      t1 = ($urandom_range(0, 3) != 0) ? 4 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 7));
      step("rand", ($urandom_range(0, 49) != 0), 2'($urandom_range(0, 3)),
           ITYPE_LEN'(t0), ITYPE_LEN'(t1), ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/te_branch_map.md
Name: te_branch_map

Overview:
- Sits directly downstream of the multi-retirement block, alongside the trace encoder packet emitter.
- Consumes per-cycle retirement blocks (valid/itype lanes) and accumulates conditional-branch outcomes into an E-Trace branch map (count + bitmap).
- Emits a registered snapshot when the map fills (MAP_LEN branches) or when the packet emitter requests a flush.
- Keeps the live map visible so the packet emitter can embed it in the packet being formed.

Parameters:
- N, 1: lanes of retirement blocks per cycle; must equal the upstream N; 1..MAP_LEN.
- MAP_LEN, 31: branch map capacity, per E-Trace.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  tracing active; low clears all state
- valid_i  in  N  block valid per lane; lane 0 is oldest
- itype_i  in  N x mure_pkg::ITYPE_LEN  block itype per lane
- flush_i  in  1  packet emitter consumed the current map; request snapshot and clear
- branches_o  out  $clog2(MAP_LEN+1)  live branch count (registered state)
- branch_map_o  out  MAP_LEN  live map; bit k = k-th oldest branch; 1 = not taken
- snap_valid_o  out  1  snapshot valid, one-cycle pulse
- snap_branches_o  out  $clog2(MAP_LEN+1)  snapshot count
- snap_map_o  out  MAP_LEN  snapshot map; bits at index >= count are 0
- snap_full_o  out  1  snapshot cause: 1 = map full, 0 = flush

Behaviour:
- Reset: all outputs 0, count 0, map 0, flush_pending 0.
- Branch classification: lane i is a branch iff valid_i[i] and itype_i[i] is mure_pkg::ITYPE_NT_BRANCH (4) or mure_pkg::ITYPE_T_BRANCH (5).
  - Bit value is 1 for not-taken (4), 0 for taken (5).
  - All other itypes, including 1 and 2 (exception/interrupt), are ignored.
- Append order: branches are appended in lane order at index = current count, then the count increments.
  - The running count is computed combinationally across lanes within the cycle.
- Full:
  - When the running count reaches MAP_LEN mid-cycle, the MAP_LEN-entry map is latched as a full snapshot (snap_full_o = 1, count = MAP_LEN).
  - Accumulation restarts at index 0 for the remaining lanes of that cycle.
  - Because N <= MAP_LEN, at most one full event occurs per cycle.
- Flush without a full event:
  - The snapshot contains the pre-cycle map plus this cycle's branches (snap_full_o = 0).
  - Next state is count 0, map 0.
  - A flush with zero branches still pulses snap_valid_o with count 0.
- Flush coinciding with a full event:
  - The full snapshot wins this cycle.
  - flush_pending is set; the residual lanes go into the live map.
  - Next cycle, the pending flush snapshots the residual map as it stood at the start of that cycle (snap_full_o = 0), and clears flush_pending.
  - That cycle's new branches start a fresh map.
  - If that same cycle also fills the map (only possible when N = MAP_LEN), the full snapshot wins again and flush_pending stays set.
  - A new flush_i arriving while flush_pending is set merges with it; no extra snapshot.
- Latency: all outputs are registered.
  - snap_* and the live map reflect an input cycle on the following clock.
  - snap_* fields are 0 whenever snap_valid_o = 0.
- enable_i low: synchronously clears count, map and flush_pending; no snapshots; inputs are ignored.
  - The cycle enable_i rises accumulates normally.
- Asynchronous reset mid-accumulation discards the map; no snapshot is emitted.
- Width rule: count saturates by construction (never exceeds MAP_LEN); map bits at index >= count are always 0.

Decomposition:
- mure_pkg additions:
  - ITYPE_NT_BRANCH = 4 and ITYPE_T_BRANCH = 5 constants.
  - BMAP_LEN = 31 and BMAP_CNT_LEN = 5.
  - Typedef bmap_snap_s {count, map, full}.
- No sub-module. Single always_comb lane-walk plus one always_ff; lane walk is a for-loop over N.

Test Plan:
- N=2, MAP_LEN=31, cycle A lanes {itype 4, itype 5}, then idle -> next cycle branches_o = 2, branch_map_o = 0b01; snap_valid_o = 0.
- 30 single not-taken branches, then cycle with lanes {4, 5} -> snap_valid_o = 1, snap_full_o = 1, snap_branches_o = 31, snap_map_o = 0x7FFFFFFF; live branches_o = 1, map = 0b0.
- 5 branches accumulated, cycle with flush_i = 1 and lane0 = itype 5 -> snap_branches_o = 6, snap_full_o = 0, bit 5 = 0; live count 0.
- 30 accumulated, flush_i with lanes {5, 4} -> full snapshot (count 31); next cycle (lane0 = 4, no flush) -> flush snapshot count 1, map 0b1; live count 1, map 0b1.
- Lanes with valid_i = 0 and itype 4, plus lanes with itype 1, 2, 6 -> count unchanged, no snapshot.
- 10 accumulated, enable_i = 0 for 1 cycle -> count 0, no snapshot; rst_ni pulsed mid-stream -> all outputs 0 asynchronously.
